// File: rtl/gpu_pkg.sv
// Encodings and default widths shared between the core scheduler and the units
// that key off core_state (PC/NZP, ALU, LSU).
package gpu_pkg;

  localparam int THREADS_DEFAULT = 4;
  localparam int PC_W_DEFAULT    = 8;
  localparam int INSTR_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // An LSU holds the core in WAIT only while its transaction is in flight.
  function automatic logic lsu_busy(input logic [1:0] state);
    return (state == LSU_REQUESTING) || (state == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Program-memory fetch handshake between a core and its instruction memory.
interface core_scheduler_if #(
  parameter int PC_W    = gpu_pkg::PC_W_DEFAULT,
  parameter int INSTR_W = gpu_pkg::INSTR_W_DEFAULT
);

  logic               mem_read_valid;
  logic [PC_W-1:0]    mem_read_address;
  logic               mem_read_ready;
  logic [INSTR_W-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

endinterface

// File: rtl/core_fetcher.sv
// FETCH handshake and the shared instruction register; fetch_done pulses on the
// edge that captures the instruction.
module core_fetcher
  import gpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  core_state_e        core_state,
  input  logic [PC_W-1:0]    current_pc,
  core_scheduler_if.master   mem,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_done
);

  logic               w_fetching;
  logic [INSTR_W-1:0] r_instruction;

  // Decoded straight from the state register so the request never glitches.
  assign w_fetching           = (core_state == CORE_FETCH);
  assign mem.mem_read_valid   = w_fetching;
  assign mem.mem_read_address = current_pc;
  assign fetch_done           = w_fetching && mem.mem_read_ready;

  // NOTE: this is a single architectural register, not a memory array, so it
  // takes a reset value; storage arrays are left unreset to stay in RAM macros.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instruction <= '0;
    end else if (fetch_done) begin
      r_instruction <= mem.mem_read_data;
    end
  end

  assign instruction = r_instruction;

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: walks each instruction through FETCH..UPDATE, gates on
// active LSUs in WAIT and commits thread 0's next PC.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS = THREADS_DEFAULT,
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(THREADS):0]  thread_count,
  core_scheduler_if.master          mem,
  output logic [INSTR_W-1:0]        instruction,
  input  logic                      decoded_ret,
  input  logic [2*THREADS-1:0]      lsu_state,
  input  logic [PC_W*THREADS-1:0]   next_pc,
  output logic [PC_W-1:0]           current_pc,
  output logic [2:0]                core_state,
  output logic                      done
);

  localparam int TC_W = $clog2(THREADS) + 1;

  core_state_e     r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic            r_done, w_done_next;
  logic            w_fetch_done;
  logic            w_lsu_busy;

  core_fetcher #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fetcher (
    .clk         (clk),
    .reset       (reset),
    .core_state  (r_state),
    .current_pc  (r_pc),
    .mem         (mem),
    .instruction (instruction),
    .fetch_done  (w_fetch_done)
  );

  // NOTE: every signal written here gets its default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    w_lsu_busy = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if ((TC_W'(i) < thread_count) && lsu_busy(lsu_state[2*i +: 2])) begin
        w_lsu_busy = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_done_next  = r_done;
    case (r_state)
      CORE_IDLE:    if (start) w_state_next = CORE_FETCH;
      CORE_FETCH:   if (w_fetch_done) w_state_next = CORE_DECODE;
      CORE_DECODE:  w_state_next = CORE_REQUEST;
      CORE_REQUEST: w_state_next = CORE_WAIT;
      CORE_WAIT:    if (!w_lsu_busy) w_state_next = CORE_EXECUTE;
      CORE_EXECUTE: w_state_next = CORE_UPDATE;
      CORE_UPDATE: begin
        if (decoded_ret) begin
          w_state_next = CORE_DONE;
          w_done_next  = 1'b1;
        end else begin
          // Divergence is unsupported; thread 0 speaks for the whole core.
          w_pc_next    = next_pc[PC_W-1:0];
          w_state_next = CORE_FETCH;
        end
      end
      CORE_DONE:    w_state_next = CORE_DONE;
      default:      w_state_next = CORE_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order or of other always_ff blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CORE_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_done  <= w_done_next;
    end
  end

  if (THREADS > 1) begin : g_unused
    logic w_unused_next_pc;
    assign w_unused_next_pc = ^next_pc[PC_W*THREADS-1:PC_W];
  end

  assign core_state = r_state;
  assign current_pc = r_pc;
  assign done       = r_done;

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
Per-core control FSM that sequences every instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
It drives the 3-bit core_state bus that the per-thread PC/NZP, ALU and LSU units key off, and owns the program-memory fetch handshake and the shared instruction register.
It consumes each thread's next_pc and commits thread 0's value as the core PC in UPDATE.

Parameters:
THREADS, 4, threads per core; width of the lsu_state and next_pc buses.
PC_W, 8, program counter / program memory address width.
INSTR_W, 16, instruction word width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset; the only clock is clk
start  in  1  begin execution from PC 0; honoured only in IDLE
thread_count  in  $clog2(THREADS)+1  active threads; thread i is active when i < thread_count
mem_read_valid  out  1  fetch request to program memory
mem_read_address  out  PC_W  fetch address (= current_pc)
mem_read_ready  in  1  program memory has data this cycle
mem_read_data  in  INSTR_W  fetched instruction
instruction  out  INSTR_W  latched instruction to the decoder
decoded_ret  in  1  decoder flag: current instruction is RET
lsu_state  in  2*THREADS  per-thread LSU state: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
next_pc  in  PC_W*THREADS  per-thread next PC from PC/NZP units; thread 0 is in [PC_W-1:0]
current_pc  out  PC_W  core PC broadcast to all threads
core_state  out  3  000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
done  out  1  kernel finished on this core

Behaviour:
- Reset values: core_state=IDLE, current_pc=0, instruction=0, done=0, mem_read_valid=0.
- All state, PC and instruction updates are registered on posedge clk. Reset has priority over every other event.
- mem_read_valid = (core_state==FETCH), decoded from the state register (glitch-free). mem_read_address = current_pc at all times.
- IDLE: on start=1 go to FETCH; otherwise stay.
- FETCH: hold the request until mem_read_ready=1 is sampled. On that edge latch instruction<=mem_read_data and go to DECODE. Minimum fetch is 1 cycle; no timeout.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. LSUs launch on this state.
- WAIT: stay while any active thread has lsu_state of 01 or 10. Otherwise go to EXECUTE.
  - Inactive threads are ignored.
  - Non-memory instructions therefore spend exactly 1 cycle in WAIT.
- EXECUTE: exactly 1 cycle, then UPDATE. The PC/NZP units compute next_pc on the edge that leaves EXECUTE, so next_pc is valid throughout UPDATE.
- UPDATE:
  - If decoded_ret=1: go to DONE and set done<=1; current_pc is unchanged.
  - Else: current_pc<=next_pc[PC_W-1:0] (thread 0) and go to FETCH.
- Divergent next_pc values across threads are not supported; only thread 0's value is used.
- DONE: terminal. done stays 1 and start is ignored until reset.
- start while not in IDLE: ignored.
- PC wrap: next_pc arithmetic belongs to the PC units; this block commits whatever value arrives, so 0xFF+1 arrives and commits as 0x00.
- thread_count=0: WAIT never stalls; the instruction stream still runs.
- Reset mid-operation (any state, including FETCH with a request outstanding): the next state is IDLE and mem_read_valid drops immediately. A late mem_read_ready in IDLE is ignored.
- Minimum non-memory instruction time: 6 cycles (FETCH..UPDATE).

Decomposition:
- Shared package gpu_pkg holds:
  - core_state encodings (IDLE..DONE; EXECUTE=3'b101, UPDATE=3'b110 must match the PC/NZP unit);
  - LSU state encodings;
  - PC_W and INSTR_W defaults.
- One natural sub-module, core_fetcher: the FETCH handshake plus the instruction register. It takes core_state and current_pc and returns instruction plus a fetch_done pulse. The FSM stays in core_scheduler.

Test Plan:
- Basic flow: reset, start=1, memory ready same cycle, instruction 0x1234 at addr 0, next_pc[0]=0x01, decoded_ret=0 -> states 001,010,011,100,101,110,001; instruction=0x1234; current_pc=0x01 after UPDATE; mem_read_valid high only in FETCH.
- Fetch stall: ready held low 3 cycles -> FETCH lasts 4 cycles, address stays at current_pc, instruction latched only on the ready edge.
- LSU wait with masking: thread_count=2, thread1 lsu_state=10 for 5 cycles, thread3 stuck at 01 -> WAIT lasts 6 cycles; thread3 is ignored.
- Branch commit: in UPDATE, next_pc[0]=0x40 and thread 1's next_pc=0x41 -> current_pc=0x40 and the next fetch address is 0x40.
- RET: decoded_ret=1 in UPDATE -> core_state=111, done=1 next cycle, current_pc unchanged; a later start pulse is ignored and done stays 1.
- Reset mid-op: assert reset in WAIT, then ready=1 in the following cycle -> core_state=000, current_pc=0, done=0, mem_read_valid=0; a restart begins fetching at 0x00.
